tpmem_seq_ctrl: RTL

- Sequencing controller for the 8x8 transpose memory in the 2-D transform path.
- Accepts 8-element rows from the upstream row stage with a valid/ready handshake and drives the transpose memory's row-write enable.
- Blocks input for the memory's fixed 8-cycle column readout, and checks that the readout arrives in the expected window.
- Counts completed blocks and frames and flags sequencing errors.

---
 rtl/tpmem_seq_ctrl_if.sv | 12 +
 rtl/tpmem_seq_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/tpmem_seq_ctrl_if.sv
// Upstream row channel into the transpose-memory sequencer: one 8-element row per
// valid/ready transfer, element 0 in the MSBs.
interface tpmem_seq_ctrl_if #(
  parameter int unsigned BW = 10
);
  logic [8*BW-1:0] data;
  logic            valid;
  logic            ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/tpmem_seq_ctrl.sv
// Sequencer for the 8x8 transpose memory: accepts 8 rows, blocks input for the fixed
// 8-cycle column readout, checks the column window and counts blocks and frames.
module tpmem_seq_ctrl #(
  parameter int unsigned BW    = 10,
  parameter int unsigned BLK_W = 16
) (
  input  logic              i_clk,
  input  logic              i_Reset,
  tpmem_seq_ctrl_if.slave   up,
  output logic [8*BW-1:0]   o_tp_data,
  output logic              o_tp_enable,
  input  logic              i_tp_en,
  input  logic [BLK_W-1:0]  i_frame_blocks,
  output logic              o_busy,
  output logic              o_blk_done,
  output logic              o_frame_done,
  output logic [BLK_W-1:0]  o_blk_cnt,
  output logic              o_err
);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

  state_e           state_q;
  logic [2:0]       row_cnt_q;
  logic [2:0]       drain_cnt_q;
  logic [3:0]       col_cnt_q;
  logic             exp_col_q;
  logic             blk_open_q;
  logic             xfer;
  logic [BLK_W-1:0] blk_cnt_inc;
  logic             frame_end;

  assign up.ready    = i_Reset & (state_q != StDrain);
  assign xfer        = up.valid & up.ready;
  assign o_tp_enable = xfer;
  assign o_tp_data   = up.data;

  assign blk_cnt_inc = o_blk_cnt + BLK_W'(1);
  assign frame_end   = (i_frame_blocks != '0) && (blk_cnt_inc == i_frame_blocks);

  // A block stays open from its 8th row until its 8th column has been counted.
  assign o_busy = (state_q != StIdle) | blk_open_q;

  always_ff @(posedge i_clk) begin
    if (!i_Reset) begin
      state_q      <= StIdle;
      row_cnt_q    <= '0;
      drain_cnt_q  <= '0;
      col_cnt_q    <= '0;
      exp_col_q    <= 1'b0;
      blk_open_q   <= 1'b0;
      o_blk_done   <= 1'b0;
      o_frame_done <= 1'b0;
      o_blk_cnt    <= '0;
      o_err        <= 1'b0;
    end else begin
      o_blk_done   <= 1'b0;
      o_frame_done <= 1'b0;

      // Columns lag DRAIN by one cycle; any disagreement is a sequencing error.
      exp_col_q <= (state_q == StDrain);
      if (i_tp_en != exp_col_q) begin
        o_err <= 1'b1;
      end

      if (col_cnt_q == 4'd8) begin
        col_cnt_q <= {3'b000, i_tp_en};
      end else if (i_tp_en) begin
        col_cnt_q <= col_cnt_q + 4'd1;
      end

      if (i_tp_en && (col_cnt_q == 4'd7)) begin
        o_blk_done <= 1'b1;
        blk_open_q <= 1'b0;
        if (frame_end) begin
          o_frame_done <= 1'b1;
          o_blk_cnt    <= '0;
        end else begin
          o_blk_cnt <= blk_cnt_inc;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (xfer) begin
            row_cnt_q <= 3'd1;
            state_q   <= StLoad;
          end
        end
        StLoad: begin
          if (xfer) begin
            if (row_cnt_q == 3'd7) begin
              row_cnt_q   <= '0;
              drain_cnt_q <= '0;
              blk_open_q  <= 1'b1;
              state_q     <= StDrain;
            end else begin
              row_cnt_q <= row_cnt_q + 3'd1;
            end
          end
        end
        StDrain: begin
          drain_cnt_q <= drain_cnt_q + 3'd1;
          if (drain_cnt_q == 3'd7) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
